l1d_dual_entry_allocator: RTL and testbench

- Tracks occupancy of an N-entry L1D resource pool, e.g. line-fill buffer or MSHR slots.
- Grants up to two new entries per cycle and retires up to two entries per cycle.
- Internally derives the free vector and picks the lowest free id for port 0 and the highest free id for port 1, using the team's two-from-N selector.
- Sits between the L1D miss pipeline (alloc requests) and the refill/writeback path (frees).

---
 rtl/l1d_dual_entry_allocator.sv | 152 +++++++++++++++
 tb/tb_l1d_dual_entry_allocator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/l1d_dual_entry_allocator.sv
// L1D dual-entry allocator: tracks busy entries of an N-entry pool such as
// line-fill buffers or MSHR slots. Up to two entries can be granted and up
// to two entries retired per cycle.

// Two-from-N selector: reports the lowest and highest set bit of a vector.
module l1d_two_from_n_sel #(
    parameter  int unsigned N  = 8,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic          any_vld,
    output logic          two_vld,
    output logic [IW-1:0] lo_id,
    output logic [IW-1:0] hi_id
);

    // Scan in both directions; the last hit in each scan is the extreme index.
    always_comb begin
        lo_id = '0;
        hi_id = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (vec[i-1]) lo_id = IW'(i - 1);
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i]) hi_id = IW'(i);
        end
        any_vld = |vec;
        two_vld = any_vld && (lo_id != hi_id);
    end

endmodule

module l1d_dual_entry_allocator #(
    parameter  int unsigned ENTRY_NUM = 8,
    localparam int unsigned ID_W      = $clog2(ENTRY_NUM),
    localparam int unsigned CNT_W     = $clog2(ENTRY_NUM + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 alloc0_req_i,
    input  logic                 alloc1_req_i,
    output logic                 alloc0_gnt_o,
    output logic                 alloc1_gnt_o,
    output logic [ID_W-1:0]      alloc0_id_o,
    output logic [ID_W-1:0]      alloc1_id_o,
    input  logic                 free0_vld_i,
    input  logic [ID_W-1:0]      free0_id_i,
    input  logic                 free1_vld_i,
    input  logic [ID_W-1:0]      free1_id_i,
    input  logic                 flush_i,
    output logic [ENTRY_NUM-1:0] busy_vec_o,
    output logic [CNT_W-1:0]     busy_cnt_o,
    output logic                 full_o,
    output logic                 empty_o
);

    logic [ENTRY_NUM-1:0] busy_vec;
    logic [CNT_W-1:0]     busy_cnt;
    logic [ENTRY_NUM-1:0] free_vec;
    logic                 any_free;
    logic                 two_free;
    logic [ID_W-1:0]      lo_id;
    logic [ID_W-1:0]      hi_id;
    logic                 gnt0;
    logic                 gnt1;
    logic [ENTRY_NUM-1:0] alloc_mask;
    logic [ENTRY_NUM-1:0] free_mask;
    logic [CNT_W-1:0]     alloc_cnt;
    logic [CNT_W-1:0]     free_cnt;
    logic [ENTRY_NUM-1:0] busy_vec_nxt;
    logic [CNT_W-1:0]     busy_cnt_nxt;

    assign free_vec = ~busy_vec;

    l1d_two_from_n_sel #(
        .N (ENTRY_NUM)
    ) u_sel (
        .vec     (free_vec),
        .any_vld (any_free),
        .two_vld (two_free),
        .lo_id   (lo_id),
        .hi_id   (hi_id)
    );

    // Grants depend only on registered occupancy; port 1 needs a second
    // distinct entry whenever port 0 is also asking.
    always_comb begin
        gnt0 = alloc0_req_i && any_free && !flush_i;
        gnt1 = alloc1_req_i && !flush_i && (alloc0_req_i ? two_free : any_free);
    end

    // Build the allocate and effective free masks plus their populations;
    // frees of idle entries are dropped and duplicate ids collapse to one bit.
    always_comb begin
        alloc_mask = '0;
        free_mask  = '0;
        free_cnt   = '0;
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            alloc_mask[i] = (gnt0 && (lo_id == ID_W'(i))) ||
                            (gnt1 && (hi_id == ID_W'(i)));
            free_mask[i]  = busy_vec[i] &&
                            ((free0_vld_i && (free0_id_i == ID_W'(i))) ||
                             (free1_vld_i && (free1_id_i == ID_W'(i))));
            free_cnt      = free_cnt + CNT_W'(free_mask[i]);
        end
        alloc_cnt = CNT_W'(gnt0) + CNT_W'(gnt1);
    end

    // Next occupancy; flush wins over every allocate and free.
    always_comb begin
        if (flush_i) begin
            busy_vec_nxt = '0;
            busy_cnt_nxt = '0;
        end else begin
            busy_vec_nxt = (busy_vec & ~free_mask) | alloc_mask;
            busy_cnt_nxt = busy_cnt + alloc_cnt - free_cnt;
        end
    end

    // Occupancy state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_vec <= '0;
            busy_cnt <= '0;
        end else begin
            busy_vec <= busy_vec_nxt;
            busy_cnt <= busy_cnt_nxt;
        end
    end

    assign alloc0_gnt_o = gnt0;
    assign alloc1_gnt_o = gnt1;
    assign alloc0_id_o  = lo_id;
    assign alloc1_id_o  = hi_id;
    assign busy_vec_o   = busy_vec;
    assign busy_cnt_o   = busy_cnt;
    assign full_o       = (busy_cnt == CNT_W'(ENTRY_NUM));
    assign empty_o      = (busy_cnt == '0);

    a_cnt_matches_vec: assert property (@(posedge clk) disable iff (!rstn)
        busy_cnt == CNT_W'($countones(busy_vec)))
        else $error("busy_cnt does not match popcount of busy_vec");

    a_free0_busy: assert property (@(posedge clk) disable iff (!rstn)
        free0_vld_i |-> busy_vec[free0_id_i])
        else $warning("free0 releases an entry that is not busy");

    a_free1_busy: assert property (@(posedge clk) disable iff (!rstn)
        free1_vld_i |-> busy_vec[free1_id_i])
        else $warning("free1 releases an entry that is not busy");

endmodule

// File: tb/tb_l1d_dual_entry_allocator.sv
// Randomized plus directed bench for l1d_dual_entry_allocator with a
// behavioural occupancy model built from per-entry flags and a free list.
module tb_l1d_dual_entry_allocator;

    localparam int N = 8;

    logic       clk;
    logic       rstn;
    logic       alloc0_req_i, alloc1_req_i;
    logic       alloc0_gnt_o, alloc1_gnt_o;
    logic [2:0] alloc0_id_o, alloc1_id_o;
    logic       free0_vld_i, free1_vld_i;
    logic [2:0] free0_id_i, free1_id_i;
    logic       flush_i;
    logic [7:0] busy_vec_o;
    logic [3:0] busy_cnt_o;
    logic       full_o, empty_o;

    int n_vec;
    int n_err;

    bit model_busy [N];
    int model_cnt;

    l1d_dual_entry_allocator #(
        .ENTRY_NUM (N)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .alloc0_req_i (alloc0_req_i),
        .alloc1_req_i (alloc1_req_i),
        .alloc0_gnt_o (alloc0_gnt_o),
        .alloc1_gnt_o (alloc1_gnt_o),
        .alloc0_id_o  (alloc0_id_o),
        .alloc1_id_o  (alloc1_id_o),
        .free0_vld_i  (free0_vld_i),
        .free0_id_i   (free0_id_i),
        .free1_vld_i  (free1_vld_i),
        .free1_id_i   (free1_id_i),
        .flush_i      (flush_i),
        .busy_vec_o   (busy_vec_o),
        .busy_cnt_o   (busy_cnt_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < N; i++) if (model_busy[i]) v = v + (32'd1 << i);
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) model_busy[i] = 0;
        model_cnt = 0;
    endtask

    task automatic check_state();
        check("busy_vec", busy_vec_o, model_vec());
        check("busy_cnt", busy_cnt_o, model_cnt);
        check("full",     full_o,     model_cnt == N);
        check("empty",    empty_o,    model_cnt == 0);
    endtask

    // One clock: drive at negedge, check combinational grants and registered
    // state, then advance the model at the posedge.
    task automatic step(input bit r0, input bit r1, input bit f0v, input int f0id,
                        input bit f1v, input int f1id, input bit fl);
        int  free_q[$];
        bit  e_g0, e_g1;
        int  e_id0, e_id1;
        alloc0_req_i = r0;
        alloc1_req_i = r1;
        free0_vld_i  = f0v;
        free0_id_i   = 3'(f0id);
        free1_vld_i  = f1v;
        free1_id_i   = 3'(f1id);
        flush_i      = fl;
        #1;
        for (int i = 0; i < N; i++) if (!model_busy[i]) free_q.push_back(i);
        e_g0  = r0 && !fl && (free_q.size() > 0);
        e_g1  = r1 && !fl && (r0 ? (free_q.size() >= 2) : (free_q.size() >= 1));
        e_id0 = (free_q.size() > 0) ? free_q[0] : 0;
        e_id1 = (free_q.size() > 0) ? free_q[free_q.size()-1] : 0;
        check("gnt0", alloc0_gnt_o, e_g0);
        check("gnt1", alloc1_gnt_o, e_g1);
        if (e_g0) check("id0", alloc0_id_o, e_id0);
        if (e_g1) check("id1", alloc1_id_o, e_id1);
        check_state();
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            if (f0v && model_busy[f0id]) begin model_busy[f0id] = 0; model_cnt--; end
            if (f1v && model_busy[f1id]) begin model_busy[f1id] = 0; model_cnt--; end
            if (e_g0) begin model_busy[e_id0] = 1; model_cnt++; end
            if (e_g1) begin model_busy[e_id1] = 1; model_cnt++; end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int busy_q[$];
        int a, b;
        n_vec = 0;
        n_err = 0;
        model_clear();
        rstn = 1'b0;
        alloc0_req_i = 0; alloc1_req_i = 0;
        free0_vld_i = 0; free0_id_i = '0;
        free1_vld_i = 0; free1_id_i = '0;
        flush_i = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Reset state, then a dual grant on an empty pool.
        idle();
        step(1, 1, 0, 0, 0, 0, 0);
        check("dual_vec_81", busy_vec_o, 8'h81);
        // Fill to F7 leaving entry 3 as the single free slot.
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("one_free_vec", busy_vec_o, 8'hF7);
        step(1, 1, 0, 0, 0, 0, 0);
        check("full_after_last", full_o, 1'b1);
        // Freed entry is not allocatable in the same cycle.
        step(1, 0, 1, 5, 0, 0, 0);
        check("cnt_after_free5", busy_cnt_o, 4'd7);
        step(1, 0, 0, 0, 0, 0, 0);
        check("refill5_vec", busy_vec_o, 8'hFF);
        // Duplicate free ids clear once; freeing an idle entry is a no-op.
        step(0, 0, 1, 2, 1, 2, 0);
        check("dup_free_vec", busy_vec_o, 8'hFB);
        step(0, 0, 1, 2, 0, 0, 0);
        check("refree_cnt", busy_cnt_o, 4'd7);
        // Rebuild 3C and flush over an alloc and a free.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 1, 0);
        step(0, 0, 1, 6, 1, 7, 0);
        check("vec_3c", busy_vec_o, 8'h3C);
        step(1, 0, 0, 0, 1, 3, 1);
        check("flush_empty", empty_o, 1'b1);
        // Port 1 alone takes the only free entry.
        repeat (4) step(1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        check("vec_fe", busy_vec_o, 8'hFE);
        step(0, 1, 0, 0, 0, 0, 0);
        check("alone1_vec", busy_vec_o, 8'hFF);
        // Asynchronous reset mid-cycle clears outputs before the next edge.
        #2 rstn = 1'b0;
        #1;
        model_clear();
        check("async_vec", busy_vec_o, 0);
        check("async_cnt", busy_cnt_o, 0);
        check("async_empty", empty_o, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        idle();

        // Random traffic: frees target busy entries, occasional flush.
        for (int k = 0; k < 400; k++) begin
            bit f0v, f1v;
            busy_q.delete();
            for (int i = 0; i < N; i++) if (model_busy[i]) busy_q.push_back(i);
            a = 0; b = 0; f0v = 0; f1v = 0;
            if (busy_q.size() > 0) begin
                f0v = ($urandom_range(0, 2) == 0);
                f1v = ($urandom_range(0, 2) == 0);
                a = busy_q[$urandom_range(0, busy_q.size() - 1)];
                b = ($urandom_range(0, 3) == 0) ? a : busy_q[$urandom_range(0, busy_q.size() - 1)];
            end
            step($urandom_range(0, 1), $urandom_range(0, 1), f0v, a, f1v, b,
                 ($urandom_range(0, 31) == 0));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
